// File: rtl/score_ctrl.sv
// Pong score keeper: two BCD scores, digit enables/blink, and the
// serve / play / game-over sequencer that gates point events.
module score_ctrl #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       FrameTick,
    input  logic       NewGame,
    input  logic       PointP1,
    input  logic       PointP2,
    output logic [3:0] P1Tens,
    output logic [3:0] P1Ones,
    output logic [3:0] P2Tens,
    output logic [3:0] P2Ones,
    output logic [3:0] DigitEn,
    output logic       ServeReady,
    output logic       ServeDir,
    output logic       GameOver,
    output logic       Winner
);

    // state      | meaning
    // S_IDLE     | waiting for NewGame, points ignored
    // S_SERVE    | counting FrameTicks before the ball is released
    // S_PLAY     | ball live, point pulses credited
    // S_GAMEOVER | scores frozen, winner's digits blink
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SERVE    = 2'd1;
    localparam logic [1:0] S_PLAY     = 2'd2;
    localparam logic [1:0] S_GAMEOVER = 2'd3;

    localparam logic [7:0] WIN_BCD    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] p1_tens_q, p1_tens_d, p1_ones_q, p1_ones_d;
    logic [3:0] p2_tens_q, p2_tens_d, p2_ones_q, p2_ones_d;
    logic [3:0] digit_en_q, digit_en_d;
    logic       serve_ready_q, serve_ready_d;
    logic       serve_dir_q, serve_dir_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic       blink_off_q, blink_off_d;
    logic [7:0] p1_next, p2_next;
    logic       blank_p1, blank_p2;

    // Saturates at 99 so the digits can never leave BCD range.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        r = {tens, ones};
        if (ones == 4'd9) begin
            if (tens != 4'd9) r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_tens_d   = p1_tens_q;
        p1_ones_d   = p1_ones_q;
        p2_tens_d   = p2_tens_q;
        p2_ones_d   = p2_ones_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        blink_off_d = blink_off_q;
        p1_next     = bcd_inc(p1_tens_q, p1_ones_q);
        p2_next     = bcd_inc(p2_tens_q, p2_ones_q);

        if (NewGame) begin
            state_d     = S_SERVE;
            cnt_d       = 8'd0;
            p1_tens_d   = 4'd0;
            p1_ones_d   = 4'd0;
            p2_tens_d   = 4'd0;
            p2_ones_d   = 4'd0;
            serve_dir_d = 1'b0;
            winner_d    = 1'b0;
            blink_off_d = 1'b0;
        end else begin
            case (state_q)
                S_SERVE: begin
                    if (FrameTick) begin
                        if (cnt_q == SERVE_LAST) begin
                            state_d = S_PLAY;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // P1 wins a simultaneous point.
                    if (PointP1) begin
                        {p1_tens_d, p1_ones_d} = p1_next;
                        cnt_d = 8'd0;
                        if (p1_next == WIN_BCD) begin
                            state_d     = S_GAMEOVER;
                            winner_d    = 1'b0;
                            blink_off_d = 1'b0;
                        end else begin
                            state_d     = S_SERVE;
                            serve_dir_d = 1'b1;
                        end
                    end else if (PointP2) begin
                        {p2_tens_d, p2_ones_d} = p2_next;
                        cnt_d = 8'd0;
                        if (p2_next == WIN_BCD) begin
                            state_d     = S_GAMEOVER;
                            winner_d    = 1'b1;
                            blink_off_d = 1'b0;
                        end else begin
                            state_d     = S_SERVE;
                            serve_dir_d = 1'b0;
                        end
                    end
                end
                S_GAMEOVER: begin
                    if (FrameTick) begin
                        if (cnt_q == BLINK_LAST) begin
                            blink_off_d = ~blink_off_q;
                            cnt_d       = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        blank_p1      = (state_d == S_GAMEOVER) && blink_off_d && !winner_d;
        blank_p2      = (state_d == S_GAMEOVER) && blink_off_d && winner_d;
        digit_en_d    = {~blank_p2, (p2_tens_d != 4'd0) && !blank_p2,
                         ~blank_p1, (p1_tens_d != 4'd0) && !blank_p1};
        serve_ready_d = (state_d == S_PLAY);
        game_over_d   = (state_d == S_GAMEOVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            p1_tens_q     <= 4'd0;
            p1_ones_q     <= 4'd0;
            p2_tens_q     <= 4'd0;
            p2_ones_q     <= 4'd0;
            digit_en_q    <= 4'b1010;
            serve_ready_q <= 1'b0;
            serve_dir_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            blink_off_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            p1_tens_q     <= p1_tens_d;
            p1_ones_q     <= p1_ones_d;
            p2_tens_q     <= p2_tens_d;
            p2_ones_q     <= p2_ones_d;
            digit_en_q    <= digit_en_d;
            serve_ready_q <= serve_ready_d;
            serve_dir_q   <= serve_dir_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            blink_off_q   <= blink_off_d;
        end
    end

    assign P1Tens     = p1_tens_q;
    assign P1Ones     = p1_ones_q;
    assign P2Tens     = p2_tens_q;
    assign P2Ones     = p2_ones_q;
    assign DigitEn    = digit_en_q;
    assign ServeReady = serve_ready_q;
    assign ServeDir   = serve_dir_q;
    assign GameOver   = game_over_q;
    assign Winner     = winner_q;

endmodule
